// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// mult_pkg : shared types and round-robin pick helper for mult_mod sharing
// Rev 1.0
// ============================================================================
package mult_pkg;

    localparam int unsigned Q         = 7681;
    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned REQ_ID_W  = $clog2(N_REQ_MAX);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } pick_t;

    // Scan descending so the last hit written is the nearest one after ptr.
    function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                      input req_id_t              ptr,
                                      input int unsigned          n);
        pick_t   r;
        req_id_t idx;
        r = '0;
        for (int k = N_REQ_MAX; k >= 1; k--) begin
            if (k <= int'(n)) begin
                idx = req_id_t'((int'(ptr) + k) % int'(n));
                if (valid[idx]) begin
                    r.found = 1'b1;
                    r.id    = idx;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant with registered last-winner ptr
// Rev 1.0
// ============================================================================
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_grant_vld,
    output req_id_t          o_grant_id
);

    req_id_t                r_ptr;
    pick_t                  w_pick;
    logic [N_REQ_MAX-1:0]   w_valid;

    assign w_valid     = N_REQ_MAX'(i_valid);
    assign w_pick      = rr_pick(w_valid, r_ptr, N_REQ);
    assign o_grant_vld = i_en & w_pick.found;
    assign o_grant_id  = w_pick.id;
    assign o_grant     = o_grant_vld ? (N_REQ'(1) << w_pick.id) : '0;

    // A grant is always an accept, so the winner becomes the new pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= req_id_t'(N_REQ - 1);
        end else if (o_grant_vld) begin
            r_ptr <= w_pick.id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_mod_arbiter.sv
`default_nettype none
// ============================================================================
// mult_mod_arbiter : shares one pipelined mult_mod among N_REQ requesters
// Rev 1.0
// ============================================================================
module mult_mod_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MULT_LAT = 3,
    parameter int unsigned WIDTH    = 13
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       mm_a,
    output logic [WIDTH-1:0]       mm_b,
    input  logic [WIDTH-1:0]       mm_prod,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic                   quiesce,
    output logic                   idle
);

    logic    w_grant_vld;
    req_id_t w_grant_id;
    logic    w_in_flight;
    tag_t    r_tag [MULT_LAT];

    rr_arbiter #(
        .N_REQ       (N_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (req_valid),
        .i_en        (~quiesce),
        .o_grant     (req_ready),
        .o_grant_vld (w_grant_vld),
        .o_grant_id  (w_grant_id)
    );

    // Operands stay at zero without a grant to keep the multiplier quiet.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_grant_vld && (w_grant_id == req_id_t'(i))) begin
                mm_a = req_a[i*WIDTH +: WIDTH];
                mm_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MULT_LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= {w_grant_vld, w_grant_id};
            for (int i = 1; i < int'(MULT_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (r_tag[MULT_LAT-1].vld) begin
            rsp_valid <= N_REQ'(1) << r_tag[MULT_LAT-1].id;
            rsp_data  <= mm_prod;
        end else begin
            rsp_valid <= '0;
        end
    end

    always_comb begin
        w_in_flight = 1'b0;
        for (int i = 0; i < int'(MULT_LAT); i++) begin
            w_in_flight = w_in_flight | r_tag[i].vld;
        end
    end

    assign idle = ~w_grant_vld & ~w_in_flight;

endmodule
`default_nettype wire

// File: tb/tb_mult_mod_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mult_mod_arbiter : vectors, corner sequences and random scoreboard run
// Rev 1.0
// ============================================================================
module tb_mult_mod_arbiter;
    import mult_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int W   = 13;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     mm_a;
    logic [W-1:0]     mm_b;
    logic [W-1:0]     mm_prod;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic             quiesce;
    logic             idle;

    int a_v [N];
    int b_v [N];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mult_mod_arbiter #(
        .N_REQ    (N),
        .MULT_LAT (LAT),
        .WIDTH    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_prod   (mm_prod),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .quiesce   (quiesce),
        .idle      (idle)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(a_v[i]);
            req_b[i*W +: W] = W'(b_v[i]);
        end
    end

    // Behavioural mult_mod: LAT register stages of (a*b) mod Q.
    int unsigned r_p [LAT];
    always @(posedge clk) begin
        r_p[0] <= (32'(mm_a) * 32'(mm_b)) % Q;
        for (int i = 1; i < LAT; i++) r_p[i] <= r_p[i-1];
    end
    assign mm_prod = W'(r_p[LAT-1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        quiesce   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: expected products in acceptance order, each due LAT+1 edges
    // after the cycle its grant is seen.
    typedef struct {
        int id;
        int prod;
        int due;
    } exp_t;
    exp_t q [$];
    int   last_win = N-1;
    int   wait_c [N];

    initial begin : monitor
        int   win, idx, vld, exp_idle;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                last_win = N-1;
                for (int i = 0; i < N; i++) wait_c[i] = 0;
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_data",  32'(rsp_data),  0);
            end else begin
                vld = int'(req_valid);
                win = -1;
                if (!quiesce) begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (last_win + k) % N;
                        if (win < 0 && ((vld >> idx) & 1) == 1) win = idx;
                    end
                end
                chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
                chk("req_ready", 32'(req_ready), (win < 0) ? 0 : (1 << win));
                chk("mm_a", 32'(mm_a), (win < 0) ? 0 : a_v[win]);
                chk("mm_b", 32'(mm_b), (win < 0) ? 0 : b_v[win]);
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 1 << e.id);
                    chk("rsp_data",  32'(rsp_data),  e.prod);
                end else begin
                    chk("rsp_quiet", 32'(rsp_valid), 0);
                end
                exp_idle = (win < 0 && q.size() == 0) ? 1 : 0;
                chk("idle", 32'(idle), exp_idle);
                for (int i = 0; i < N; i++) begin
                    if (((vld >> i) & 1) == 0 || win == i) wait_c[i] = 0;
                    else if (!quiesce) wait_c[i]++;
                    chk("no_starve", (wait_c[i] < N) ? 1 : 0, 1);
                end
                if (win >= 0) begin
                    q.push_back('{id: win, prod: (a_v[win] * b_v[win]) % Q, due: cyc + 1 + LAT});
                    last_win = win;
                end
            end
        end
    end

    typedef struct {
        logic [N-1:0] valid;
        logic         qsc;
        int           rdy;
        int           ma;
        int           mb;
        int           idl;
    } vec_t;
    vec_t tbl [6];

    initial begin : stimulus
        int vr, rdy, bit_v;

        rst_n     = 1'b0;
        req_valid = '0;
        quiesce   = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = 100 + i;
            b_v[i] = 200 + i;
        end

        // Arbitration from the reset pointer, evaluated while reset is held.
        tbl[0] = '{valid: 4'b0000, qsc: 1'b0, rdy: 4'b0000, ma: 0,   mb: 0,   idl: 1};
        tbl[1] = '{valid: 4'b0110, qsc: 1'b0, rdy: 4'b0010, ma: 101, mb: 201, idl: 0};
        tbl[2] = '{valid: 4'b1000, qsc: 1'b0, rdy: 4'b1000, ma: 103, mb: 203, idl: 0};
        tbl[3] = '{valid: 4'b1111, qsc: 1'b1, rdy: 4'b0000, ma: 0,   mb: 0,   idl: 1};
        tbl[4] = '{valid: 4'b1111, qsc: 1'b0, rdy: 4'b0001, ma: 100, mb: 200, idl: 0};
        tbl[5] = '{valid: 4'b1100, qsc: 1'b0, rdy: 4'b0100, ma: 102, mb: 202, idl: 0};
        #1;
        for (int t = 0; t < 6; t++) begin
            req_valid = tbl[t].valid;
            quiesce   = tbl[t].qsc;
            #0.5;
            chk("tbl_ready", 32'(req_ready), tbl[t].rdy);
            chk("tbl_mm_a",  32'(mm_a),      tbl[t].ma);
            chk("tbl_mm_b",  32'(mm_b),      tbl[t].mb);
            chk("tbl_idle",  32'(idle),      tbl[t].idl);
        end
        chk("tbl_rsp_data", 32'(rsp_data), 0);

        // Single requester latency and product.
        reset_dut();
        a_v[0] = 4592; b_v[0] = 6651;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("s1_ready", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("s1_rsp_valid", 32'(rsp_valid), 1);
        chk("s1_rsp_data",  32'(rsp_data),  1736);

        // Two contending requesters straight after reset.
        reset_dut();
        a_v[1] = 5623; b_v[1] = 7265;
        a_v[2] = 4592; b_v[2] = 6651;
        req_valid = 4'b0110;
        @(negedge clk);
        chk("s2_ready0", 32'(req_ready), 4'b0010);
        tick();
        @(negedge clk);
        chk("s2_ready1", 32'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("s2_rsp0_valid", 32'(rsp_valid), 4'b0010);
        chk("s2_rsp0_data",  32'(rsp_data),  3537);
        tick();
        @(negedge clk);
        chk("s2_rsp1_valid", 32'(rsp_valid), 4'b0100);
        chk("s2_rsp1_data",  32'(rsp_data),  1736);

        // All four valid: strict rotation.
        reset_dut();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("s3_rotate", 32'(req_ready), 1 << (k % N));
            tick();
        end
        req_valid = '0;
        repeat (LAT + 2) tick();

        // Quiesce while requester 0 streams.
        req_valid = 4'b0001;
        repeat (4) tick();
        quiesce = 1'b1;
        #1;
        chk("s4_ready_blocked", 32'(req_ready), 0);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            chk("s4_idle", 32'(idle), (k == LAT + 1) ? 1 : 0);
            tick();
        end
        quiesce   = 1'b0;
        req_valid = '0;
        tick();

        // Reset with two operations in flight.
        req_valid = 4'b0010;
        repeat (2) tick();
        req_valid = '0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("s5_no_rsp",   32'(rsp_valid), 0);
            chk("s5_rsp_data", 32'(rsp_data),  0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("s5_restart", 32'(req_ready), 4'b0001);
        req_valid = '0;
        tick();

        // Random traffic; a requester holds its operands until accepted.
        vr = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rdy = int'(req_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (((vr >> i) & 1) == 0 || ((rdy >> i) & 1) == 1) begin
                    bit_v  = int'($urandom_range(0, 1));
                    vr     = (vr & ~(1 << i)) | (bit_v << i);
                    a_v[i] = int'($urandom_range(0, Q - 1));
                    b_v[i] = int'($urandom_range(0, Q - 1));
                end
            end
            req_valid = N'(vr);
            quiesce   = ($urandom_range(0, 15) == 0);
        end
        req_valid = '0;
        quiesce   = 1'b0;
        repeat (LAT + 3) tick();
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 0);
        chk("drain_idle",  32'(idle),     1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
